// File: rtl/clock_pkg.sv
// Wrap limits and load-validation helper shared by the time counter and the 1 Hz tick generator.
package clock_pkg;

  localparam logic [7:0]  SEC_MAX  = 8'h59;
  localparam logic [7:0]  MIN_MAX  = 8'h59;
  localparam logic [7:0]  HOUR_MAX = 8'h23;
  localparam int unsigned TICK_DIV = 50_000_000;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } bcd_time_t;

  // With both nibbles <= 9 a plain binary compare orders BCD values correctly.
  function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

endpackage

// File: rtl/time_counter_if.sv
// Tick/load request and time/status bundle between the clock controller and the time counter.
interface time_counter_if;
  logic       tick;
  logic       set_en;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic [7:0] set_ss;
  logic       set_ack;
  logic       set_err;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       day_tick;

  modport master (
    output tick, set_en, set_hh, set_mm, set_ss,
    input  set_ack, set_err, hour_bcd, min_bcd, sec_bcd, day_tick
  );

  modport slave (
    input  tick, set_en, set_hh, set_mm, set_ss,
    output set_ack, set_err, hour_bcd, min_bcd, sec_bcd, day_tick
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at max to 00; load has priority over inc.
module bcd_mod_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [7:0] max,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] r_value;
  logic [7:0] w_next;

  always_comb begin
    w_next = r_value;
    if (r_value == max)
      w_next = '0;
    else if (r_value[3:0] == 4'd9)
      w_next = {r_value[7:4] + 4'd1, 4'd0};
    else
      w_next = {r_value[7:4], r_value[3:0] + 4'd1};
  end

  always_ff @(posedge clk) begin
    if (!rst)
      r_value <= '0;
    else if (load)
      r_value <= load_val;
    else if (inc)
      r_value <= w_next;
  end

  // Combinational so the next stage increments on the same edge.
  assign carry = inc && (r_value == max);
  assign value = r_value;

endmodule

// File: rtl/time_counter.sv
// HH:MM:SS BCD time-of-day counter with validated load and day rollover strobe.
module time_counter
  import clock_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  time_counter_if.slave bus
);

  logic       w_load_ok;
  logic       w_load;
  logic       w_sec_inc;
  logic       w_sec_carry;
  logic       w_min_carry;
  logic       w_hour_carry;
  logic [7:0] w_sec;
  logic [7:0] w_min;
  logic [7:0] w_hour;
  logic       r_ack;
  logic       r_err;
  logic       r_day_tick;

  assign w_load_ok = bcd_in_range(bus.set_hh, HOUR_MAX) &&
                     bcd_in_range(bus.set_mm, MIN_MAX)  &&
                     bcd_in_range(bus.set_ss, SEC_MAX);
  assign w_load    = bus.set_en && w_load_ok;
  // An accepted load swallows a coincident tick so no carry or day_tick can escape.
  assign w_sec_inc = bus.tick && !w_load;

  bcd_mod_counter u_sec (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_sec_inc),
    .load     (w_load),
    .load_val (bus.set_ss),
    .max      (SEC_MAX),
    .value    (w_sec),
    .carry    (w_sec_carry)
  );

  bcd_mod_counter u_min (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_sec_carry),
    .load     (w_load),
    .load_val (bus.set_mm),
    .max      (MIN_MAX),
    .value    (w_min),
    .carry    (w_min_carry)
  );

  bcd_mod_counter u_hour (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_min_carry),
    .load     (w_load),
    .load_val (bus.set_hh),
    .max      (HOUR_MAX),
    .value    (w_hour),
    .carry    (w_hour_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_day_tick <= 1'b0;
    end else begin
      r_ack      <= w_load;
      r_err      <= bus.set_en && !w_load_ok;
      r_day_tick <= w_hour_carry;
    end
  end

  assign bus.set_ack  = r_ack;
  assign bus.set_err  = r_err;
  assign bus.day_tick = r_day_tick;
  assign bus.sec_bcd  = w_sec;
  assign bus.min_bcd  = w_min;
  assign bus.hour_bcd = w_hour;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: reset, carries, rollover, load validation and collisions.
module tb_time_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_chk  = 0;

  always #10 clk = ~clk;

  time_counter_if bus ();

  time_counter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input logic [7:0] hh, input logic [7:0] mm,
                          input logic [7:0] ss);
    chk({tag, ".hh"}, bus.hour_bcd, hh);
    chk({tag, ".mm"}, bus.min_bcd, mm);
    chk({tag, ".ss"}, bus.sec_bcd, ss);
  endtask

  task automatic chk_pulse(input string tag, input logic ack, input logic err, input logic day);
    chk({tag, ".ack"}, {7'd0, bus.set_ack}, {7'd0, ack});
    chk({tag, ".err"}, {7'd0, bus.set_err}, {7'd0, err});
    chk({tag, ".day"}, {7'd0, bus.day_tick}, {7'd0, day});
  endtask

  // Present inputs for one edge, then sample 1 time unit after it.
  task automatic cyc(input logic t, input logic se, input logic [7:0] hh,
                     input logic [7:0] mm, input logic [7:0] ss);
    bus.tick   = t;
    bus.set_en = se;
    bus.set_hh = hh;
    bus.set_mm = mm;
    bus.set_ss = ss;
    @(posedge clk);
    #1;
    bus.tick   = 1'b0;
    bus.set_en = 1'b0;
  endtask

  initial begin
    logic [7:0] e_ss;
    logic [7:0] e_mm;
    int         s;

    bus.tick = 1'b0; bus.set_en = 1'b0;
    bus.set_hh = '0; bus.set_mm = '0; bus.set_ss = '0;

    // Reset for two cycles, with a tick and a load request that must be ignored.
    rst = 1'b0;
    cyc(1'b1, 1'b1, 8'h12, 8'h34, 8'h56);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_time("reset", 8'h00, 8'h00, 8'h00);
    chk_pulse("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_time("idle", 8'h00, 8'h00, 8'h00);

    // 60 consecutive ticks; expected seconds converted from decimal here.
    for (int i = 1; i <= 60; i++) begin
      cyc(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      s    = i % 60;
      e_ss = 8'((s / 10) * 16 + (s % 10));
      e_mm = (i == 60) ? 8'h01 : 8'h00;
      chk($sformatf("secrun%0d.ss", i), bus.sec_bcd, e_ss);
      chk($sformatf("secrun%0d.mm", i), bus.min_bcd, e_mm);
    end
    chk_time("min_carry", 8'h00, 8'h01, 8'h00);

    // Day rollover.
    cyc(1'b0, 1'b1, 8'h23, 8'h59, 8'h58);
    chk_time("load_235958", 8'h23, 8'h59, 8'h58);
    chk_pulse("load_235958", 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_time("tick_235959", 8'h23, 8'h59, 8'h59);
    chk_pulse("tick_235959", 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_time("rollover", 8'h00, 8'h00, 8'h00);
    chk_pulse("rollover", 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_time("after_roll", 8'h00, 8'h00, 8'h00);
    chk_pulse("after_roll", 1'b0, 1'b0, 1'b0);

    // Hour carry 09:59:59 -> 10:00:00.
    cyc(1'b0, 1'b1, 8'h09, 8'h59, 8'h59);
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_time("hour_09_10", 8'h10, 8'h00, 8'h00);
    chk_pulse("hour_09_10", 1'b0, 1'b0, 1'b0);

    // Invalid loads with set_en held on consecutive cycles.
    cyc(1'b0, 1'b1, 8'h12, 8'h34, 8'h56);
    chk_pulse("load_123456", 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h24, 8'h00, 8'h00);
    chk_time("bad_hh24", 8'h12, 8'h34, 8'h56);
    chk_pulse("bad_hh24", 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 8'h12, 8'h60, 8'h00);
    chk_time("bad_mm60", 8'h12, 8'h34, 8'h56);
    chk_pulse("bad_mm60", 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 8'h12, 8'h0A, 8'h00);
    chk_time("bad_mm0A", 8'h12, 8'h34, 8'h56);
    chk_pulse("bad_mm0A", 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 8'h1A, 8'h00, 8'h00);
    chk_pulse("bad_hh1A", 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 8'h00, 8'h5F);
    chk_pulse("bad_ss5F", 1'b0, 1'b1, 1'b0);
    // A tick alongside a rejected load still counts.
    cyc(1'b1, 1'b1, 8'h12, 8'h5A, 8'h00);
    chk_time("bad_with_tick", 8'h12, 8'h34, 8'h57);
    chk_pulse("bad_with_tick", 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_pulse("err_clear", 1'b0, 1'b0, 1'b0);

    // Load/tick collision: load wins, tick discarded.
    cyc(1'b1, 1'b1, 8'h10, 8'h20, 8'h30);
    chk_time("collide", 8'h10, 8'h20, 8'h30);
    chk_pulse("collide", 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_time("collide_hold", 8'h10, 8'h20, 8'h30);
    chk_pulse("collide_hold", 1'b0, 1'b0, 1'b0);

    // Loading 00:00:00 over a would-be rollover tick gives no day_tick.
    cyc(1'b0, 1'b1, 8'h23, 8'h59, 8'h59);
    cyc(1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    chk_time("load_zero", 8'h00, 8'h00, 8'h00);
    chk_pulse("load_zero", 1'b1, 1'b0, 1'b0);

    // Reset on the rollover edge.
    cyc(1'b0, 1'b1, 8'h23, 8'h59, 8'h59);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_time("rst_midcarry", 8'h00, 8'h00, 8'h00);
    chk_pulse("rst_midcarry", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_time("post_rst", 8'h00, 8'h00, 8'h01);
    chk_pulse("post_rst", 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
